// File: rtl/kuznechik_pkg.sv
// Shared types and constants for the Kuznechik round-key scheduler.
package kuznechik_pkg;

  localparam int NKEYS_DEF = 10;
  localparam int KEY_W     = 128;
  localparam int PAIR_W    = 256;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GEN   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_READY = 3'd3,
    ST_BUSY  = 3'd4
  } sched_state_e;

  // Address width for an n-entry key buffer, never narrower than one bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kuznechik_key_buf.sv
// NKEYS x 128 round-key register file: one pair-write port, one read port.
// The read port sees a pair being written in the same cycle.
module kuznechik_key_buf
  import kuznechik_pkg::*;
#(
  parameter int NKEYS = NKEYS_DEF,
  parameter int AW    = addr_w(NKEYS)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_idx,
  input  logic [PAIR_W-1:0] wr_pair,
  input  logic [AW-1:0]     rd_idx,
  output logic [KEY_W-1:0]  rd_key
);

  logic [KEY_W-1:0] mem_q [NKEYS];
  logic [AW-1:0]    wr_idx_lo;

  assign wr_idx_lo = wr_idx + AW'(1);

  // Key storage; contents survive reset on purpose.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_idx]    <= wr_pair[PAIR_W-1:KEY_W];
      mem_q[wr_idx_lo] <= wr_pair[KEY_W-1:0];
    end
  end

  // Read with write-through bypass.
  always_comb begin
    if (wr_en && (rd_idx == wr_idx)) begin
      rd_key = wr_pair[PAIR_W-1:KEY_W];
    end else if (wr_en && (rd_idx == wr_idx_lo)) begin
      rd_key = wr_pair[KEY_W-1:0];
    end else begin
      rd_key = mem_q[rd_idx];
    end
  end

endmodule

// File: rtl/kuznechik_key_sched.sv
// Kuznechik round-key scheduler: collects key pairs, loads them into the cipher core, gates blocks.
// Optional KUZ_SCHED_KEYCHECK_EN flags a malformed keygen sequence on err.
module kuznechik_key_sched
  import kuznechik_pkg::*;
#(
  parameter int NKEYS = NKEYS_DEF,
  parameter int CNT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              kg_en,
  input  logic              kg_pair_valid,
  input  logic [PAIR_W-1:0] kg_pair,
  input  logic              kg_done,
  output logic              enc_keyset,
  output logic              enc_key_valid,
  output logic [KEY_W-1:0]  enc_round_key,
  output logic              enc_put,
  input  logic              enc_ready,
  input  logic              blk_valid,
  output logic              blk_ready,
  output logic              blk_done,
  output logic              keys_loaded,
  output logic              err
);

  localparam int              AW       = addr_w(NKEYS);
  localparam logic [CNT_W:0]  IDX_FULL = (CNT_W+1)'(NKEYS);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(NKEYS - 1);

  sched_state_e     state_q, state_d;
  logic [CNT_W:0]   idx_q, idx_d, idx_nx_s;
  logic [CNT_W-1:0] rd_q, rd_d, rd_next_s;
  logic             pend_q, pend_d, err_q, err_d;
  logic             kg_en_q, kg_en_d, keyset_q, keyset_d, key_vld_q, key_vld_d;
  logic [KEY_W-1:0] key_q, key_d, rd_key_s;
  logic             put_q, put_d, blk_ready_q, blk_ready_d, loaded_q, loaded_d;
  logic             wr_en_s, chk_fail_s;
  logic [AW-1:0]    rd_idx_s;

  assign rd_next_s = rd_q + CNT_W'(1);
  // The key for the next LOAD cycle is fetched one cycle ahead so the output is a register.
  assign rd_idx_s  = (state_q == ST_LOAD) ? rd_next_s[AW-1:0] : '0;

  kuznechik_key_buf #(.NKEYS(NKEYS), .AW(AW)) u_buf (
    .clk    (clk),
    .wr_en  (wr_en_s),
    .wr_idx (idx_q[AW-1:0]),
    .wr_pair(kg_pair),
    .rd_idx (rd_idx_s),
    .rd_key (rd_key_s)
  );

  // Next-state and datapath decisions.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    rd_d       = rd_q;
    pend_d     = pend_q;
    err_d      = err_q;
    key_vld_d  = 1'b0;
    key_d      = '0;
    put_d      = 1'b0;
    wr_en_s    = 1'b0;
    idx_nx_s   = idx_q;
    chk_fail_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_GEN;
          idx_d   = '0;
          err_d   = 1'b0;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GEN: begin
        if (kg_pair_valid && (idx_q != IDX_FULL)) begin
          wr_en_s  = 1'b1;
          idx_nx_s = idx_q + (CNT_W+1)'(2);
        end else begin
          idx_nx_s = idx_q;
        end
        idx_d = idx_nx_s;
`ifdef KUZ_SCHED_KEYCHECK_EN
        chk_fail_s = (kg_pair_valid && (idx_q == IDX_FULL)) || (kg_done && (idx_nx_s != IDX_FULL));
`else
        chk_fail_s = 1'b0;
`endif
        if (chk_fail_s) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end else if (kg_done) begin
          state_d   = ST_LOAD;
          rd_d      = '0;
          key_vld_d = 1'b1;
          key_d     = rd_key_s;
        end else begin
          state_d = ST_GEN;
        end
      end
      ST_LOAD: begin
        if (rd_q == RD_LAST) begin
          state_d = ST_READY;
        end else begin
          rd_d      = rd_next_s;
          key_vld_d = 1'b1;
          key_d     = rd_key_s;
        end
      end
      ST_READY: begin
        if (start) begin
          state_d = ST_GEN;
          idx_d   = '0;
          err_d   = 1'b0;
        end else if (blk_valid) begin
          state_d = ST_BUSY;
          put_d   = 1'b1;
        end else begin
          state_d = ST_READY;
        end
      end
      ST_BUSY: begin
        if (enc_ready && (start || pend_q)) begin
          state_d = ST_GEN;
          idx_d   = '0;
          pend_d  = 1'b0;
          err_d   = 1'b0;
        end else if (enc_ready) begin
          state_d = ST_READY;
          pend_d  = 1'b0;
        end else begin
          pend_d = pend_q | start;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs follow the state being entered.
  always_comb begin
    kg_en_d     = (state_d == ST_GEN);
    keyset_d    = (state_d == ST_GEN) || (state_d == ST_LOAD);
    blk_ready_d = (state_d == ST_READY);
    loaded_d    = (state_d == ST_READY) || (state_d == ST_BUSY);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      rd_q        <= '0;
      pend_q      <= 1'b0;
      err_q       <= 1'b0;
      kg_en_q     <= 1'b0;
      keyset_q    <= 1'b0;
      key_vld_q   <= 1'b0;
      key_q       <= '0;
      put_q       <= 1'b0;
      blk_ready_q <= 1'b0;
      loaded_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_q        <= rd_d;
      pend_q      <= pend_d;
      err_q       <= err_d;
      kg_en_q     <= kg_en_d;
      keyset_q    <= keyset_d;
      key_vld_q   <= key_vld_d;
      key_q       <= key_d;
      put_q       <= put_d;
      blk_ready_q <= blk_ready_d;
      loaded_q    <= loaded_d;
    end
  end

  assign kg_en         = kg_en_q;
  assign enc_keyset    = keyset_q;
  assign enc_key_valid = key_vld_q;
  assign enc_round_key = key_q;
  assign enc_put       = put_q;
  assign blk_ready     = blk_ready_q;
  assign keys_loaded   = loaded_q;
  assign err           = err_q;
  assign blk_done      = (state_q == ST_BUSY) && enc_ready;

endmodule
